// File: rtl/register_file_sb_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package register_file_sb_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Number of address bits needed to index nregs entries (minimum 1).
  function automatic int addr_width(input int nregs);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < nregs) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register plus a registered count of
// the flags that are set.
module regfile_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_valid,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pending_count
);

  logic [NREGS-1:0] busy_next;
  logic [AW:0]      count_next;

  // The set is applied after the clear so a new producer wins over a retiring one.
  always_comb begin
    busy_next = busy;
    if (clr_valid) busy_next[clr_addr] = 1'b0;
    if (set_valid) busy_next[set_addr] = 1'b1;
    if (ZERO_REG)  busy_next[0]        = 1'b0;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_next = count_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with optional zero register, write-to-read
// forwarding and a busy-bit scoreboard for pending producers.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   readRegister1,
  input  logic [AW-1:0]   readRegister2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic            busy1,
  output logic            busy2,
  input  logic            regWrite,
  input  logic [AW-1:0]   writeRegister,
  input  logic [XLEN-1:0] writeData,
  input  logic            reserveValid,
  input  logic [AW-1:0]   reserveRegister,
  output logic [AW:0]     pendingCount
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             write_en;
  logic             hit1;
  logic             hit2;

  assign write_en = regWrite && !(ZERO_REG && (writeRegister == '0));
  assign hit1     = regWrite && (writeRegister == readRegister1);
  assign hit2     = regWrite && (writeRegister == readRegister2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[writeRegister] <= writeData;
    end
  end

  // Reset gating keeps forwarded write data from leaking out while rst_n is low.
  always_comb begin
    readData1 = regs[readRegister1];
    readData2 = regs[readRegister2];
    if (BYPASS && hit1 && write_en) readData1 = writeData;
    if (BYPASS && hit2 && write_en) readData2 = writeData;
    if (ZERO_REG && (readRegister1 == '0)) readData1 = '0;
    if (ZERO_REG && (readRegister2 == '0)) readData2 = '0;
    if (!rst_n) begin
      readData1 = '0;
      readData2 = '0;
    end
  end

  always_comb begin
    busy1 = busy[readRegister1];
    busy2 = busy[readRegister2];
    if (BYPASS && hit1) busy1 = 1'b0;
    if (BYPASS && hit2) busy2 = 1'b0;
    if (!rst_n) begin
      busy1 = 1'b0;
      busy2 = 1'b0;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_valid     (reserveValid),
    .set_addr      (reserveRegister),
    .clr_valid     (regWrite),
    .clr_addr      (writeRegister),
    .busy          (busy),
    .pending_count (pendingCount)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: hand-derived vector table, randomized traffic
// against an array model, and an asynchronous mid-cycle reset sequence.
module tb_register_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   readRegister1, readRegister2, writeRegister, reserveRegister;
  logic            regWrite, reserveValid;
  logic [XLEN-1:0] writeData;
  logic [XLEN-1:0] readData1, readData2, nb_data1, nb_data2;
  logic            busy1, busy2, nb_busy1, nb_busy2;
  logic [AW:0]     pendingCount, nb_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .busy1(busy1), .busy2(busy2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .reserveValid(reserveValid), .reserveRegister(reserveRegister),
    .pendingCount(pendingCount)
  );

  register_file_sb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(nb_data1), .readData2(nb_data2),
    .busy1(nb_busy1), .busy2(nb_busy2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .reserveValid(reserveValid), .reserveRegister(reserveRegister),
    .pendingCount(nb_count)
  );

  // Reference state: register contents and pending flags as the rules define them.
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rv;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   r1;
    logic [AW-1:0]   r2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic            b1;
    logic            b2;
    logic [AW:0]     pc;
    logic [XLEN-1:0] nb1;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                              input logic rv, input logic [AW-1:0] ra,
                              input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                              input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                              input logic b1, input logic b2, input logic [AW:0] pc,
                              input logic [XLEN-1:0] nb1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.r1 = r1; v.r2 = r2;
    v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.pc = pc; v.nb1 = nb1;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit bypass);
    if (a == 0) return '0;
    if (bypass && regWrite && writeRegister == a) return writeData;
    return m_regs[a];
  endfunction

  function automatic logic m_busy_rd(input logic [AW-1:0] a, input bit bypass);
    if (bypass && regWrite && writeRegister == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic m_commit();
    if (regWrite && writeRegister != 0) begin
      m_regs[writeRegister] = writeData;
      m_busy[writeRegister] = 1'b0;
    end
    if (reserveValid && reserveRegister != 0) m_busy[reserveRegister] = 1'b1;
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    regWrite = we; writeRegister = wa; writeData = wd;
    reserveValid = rv; reserveRegister = ra;
    readRegister1 = r1; readRegister2 = r2;
  endtask

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, " d1"}, readData1, m_read(readRegister1, 1'b1));
    checkOutput({tag, " d2"}, readData2, m_read(readRegister2, 1'b1));
    checkOutput({tag, " b1"}, {31'd0, busy1}, {31'd0, m_busy_rd(readRegister1, 1'b1)});
    checkOutput({tag, " b2"}, {31'd0, busy2}, {31'd0, m_busy_rd(readRegister2, 1'b1)});
    checkOutput({tag, " pc"}, {26'd0, pendingCount}, $countones(m_busy));
    checkOutput({tag, " nb d1"}, nb_data1, m_read(readRegister1, 1'b0));
    checkOutput({tag, " nb d2"}, nb_data2, m_read(readRegister2, 1'b0));
    checkOutput({tag, " nb b1"}, {31'd0, nb_busy1}, {31'd0, m_busy_rd(readRegister1, 1'b0)});
    checkOutput({tag, " nb pc"}, {26'd0, nb_count}, $countones(m_busy));
  endtask

  // Inputs are held from just after one rising edge until just after the next.
  task automatic model_cycle(input string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    m_commit();
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0,            0, 0, 0, 1, 0,            0,    0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1,            0, 0, 0, 1, 0,            0,    0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1,            0, 0, 0, 1, 0,            1,    0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0, 1, 0,            1,    0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 1, 32'hDEADBEEF, 1,    0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,            0, 0, 5, 0, 32'hDEADBEEF, 0,    0, 0, 0, 32'hDEADBEEF);
    vecs[6]  = mk(0, 0, 0,            1, 3, 3, 7, 0,            0,    0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,            1, 7, 3, 7, 0,            0,    1, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0,            0, 0, 3, 7, 0,            0,    1, 1, 2, 0);
    vecs[9]  = mk(1, 3, 32'h33,       0, 0, 3, 7, 32'h33,       0,    0, 1, 2, 0);
    vecs[10] = mk(0, 0, 0,            0, 0, 3, 7, 32'h33,       0,    0, 1, 1, 32'h33);
    vecs[11] = mk(0, 0, 0,            1, 4, 4, 7, 0,            0,    0, 1, 1, 0);
    vecs[12] = mk(1, 4, 32'h44,       1, 4, 4, 7, 32'h44,       0,    0, 1, 2, 0);
    vecs[13] = mk(0, 0, 0,            0, 0, 4, 7, 32'h44,       0,    1, 1, 2, 32'h44);
    vecs[14] = mk(0, 0, 0,            1, 4, 4, 0, 32'h44,       0,    1, 0, 2, 32'h44);
    vecs[15] = mk(0, 0, 0,            0, 0, 4, 3, 32'h44,       32'h33, 1, 0, 2, 32'h44);
    vecs[16] = mk(0, 0, 0,            1, 0, 0, 4, 0,            32'h44, 0, 1, 2, 0);
    vecs[17] = mk(0, 0, 0,            0, 0, 0, 4, 0,            32'h44, 0, 1, 2, 0);
    vecs[18] = mk(1, 9, 32'h99,       1, 2, 9, 2, 32'h99,       0,    0, 0, 2, 0);
    vecs[19] = mk(0, 0, 0,            0, 0, 9, 2, 32'h99,       0,    0, 1, 3, 32'h99);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    m_clear();
    repeat (2) @(posedge clk);
    #3;
    checkOutput("in_reset d1", readData1, 0);
    checkOutput("in_reset pc", {26'd0, pendingCount}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].r1, vecs[i].r2);
      @(negedge clk);
      checkOutput($sformatf("vec%0d d1", i), readData1, vecs[i].d1);
      checkOutput($sformatf("vec%0d d2", i), readData2, vecs[i].d2);
      checkOutput($sformatf("vec%0d b1", i), {31'd0, busy1}, {31'd0, vecs[i].b1});
      checkOutput($sformatf("vec%0d b2", i), {31'd0, busy2}, {31'd0, vecs[i].b2});
      checkOutput($sformatf("vec%0d pc", i), {26'd0, pendingCount}, {26'd0, vecs[i].pc});
      checkOutput($sformatf("vec%0d nb d1", i), nb_data1, vecs[i].nb1);
      @(posedge clk);
      m_commit();
      #1;
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)), $urandom,
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)),
                    AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
      if (i % 4 == 0) readRegister1 = writeRegister;
      if (i % 5 == 0) reserveRegister = writeRegister;
      model_cycle($sformatf("rand%0d", i));
    end

    applyStimulus(1, 2, 32'h2222, 1, 2, 2, 9);
    model_cycle("load2");
    applyStimulus(1, 9, 32'h9999, 1, 9, 2, 9);
    model_cycle("load9");
    applyStimulus(1, 31, 32'h3131, 1, 31, 2, 9);
    model_cycle("load31");
    applyStimulus(0, 0, 0, 0, 0, 2, 31);
    model_cycle("loaded");

    applyStimulus(1, 5, 32'hFFFF_FFFF, 1, 6, 5, 31);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst d1", readData1, 0);
    checkOutput("arst d2", readData2, 0);
    checkOutput("arst b2", {31'd0, busy2}, 0);
    checkOutput("arst pc", {26'd0, pendingCount}, 0);
    readRegister1 = 2;
    readRegister2 = 9;
    #1;
    checkOutput("arst r2", readData1, 0);
    checkOutput("arst r9", readData2, 0);
    checkOutput("arst nb r9", nb_data2, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 5, 6);
    #2;
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    checkOutput("post_rst r5", readData1, 0);
    checkOutput("post_rst b6", {31'd0, busy2}, 0);
    checkOutput("post_rst pc", {26'd0, pendingCount}, 0);
    @(posedge clk);
    #1;
    applyStimulus(1, 10, 32'hA5A5_0001, 1, 12, 10, 12);
    model_cycle("first_edge");
    applyStimulus(0, 0, 0, 0, 0, 10, 12);
    @(negedge clk);
    checkOutput("first_edge r10", readData1, 32'hA5A5_0001);
    checkOutput("first_edge b12", {31'd0, busy2}, 1);
    checkOutput("first_edge pc", {26'd0, pendingCount}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
